// File: rtl/pkg_parameters.sv
// Shared types and constants for the quantised sign-correlation generator.
package pkg_parameters;
  localparam int FEATURE_MAP_RESOLUTION = 8;
  localparam int QCORR_LAG_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    COMPUTE,
    EMIT,
    GAP,
    FGAP
  } qcorr_gen_state_t;
endpackage

// File: rtl/qcorr_gen_if.sv
// Sample-pair input handshake plus correlation strobe outputs of qcorr_gen.
// The master side is the sample source and result consumer; the slave side is the generator.
import pkg_parameters::*;

interface qcorr_gen_if #(
  parameter int LAG_W = QCORR_LAG_W
);
  logic                                     enable_i;
  logic [LAG_W-1:0]                         lag_i;
  logic                                     in_valid_i;
  logic signed [FEATURE_MAP_RESOLUTION-1:0] in_a_i;
  logic signed [FEATURE_MAP_RESOLUTION-1:0] in_b_i;
  logic                                     in_ready_o;
  logic                                     qcorr_valid_o;
  logic                                     qcorr_data_o;
  logic                                     frame_done_o;

  modport master (
    output enable_i, lag_i, in_valid_i, in_a_i, in_b_i,
    input  in_ready_o, qcorr_valid_o, qcorr_data_o, frame_done_o
  );

  modport slave (
    input  enable_i, lag_i, in_valid_i, in_a_i, in_b_i,
    output in_ready_o, qcorr_valid_o, qcorr_data_o, frame_done_o
  );
endinterface

// File: rtl/qcorr_sign_delay.sv
// Circular 1-bit sign history: writes at the pointer, returns the sign 'lag' writes back, registered.
// lag=0 returns the sign written on the same edge; history survives frames, cleared only by reset.
module qcorr_sign_delay #(
  parameter int LAG_MAX = 64,
  parameter int LAG_W   = $clog2(LAG_MAX)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic             wr_bit,
  input  logic [LAG_W-1:0] lag,
  output logic             rd_bit
);
  logic [LAG_MAX-1:0] mem;
  logic [LAG_W-1:0]   wr_ptr;
  logic [LAG_W-1:0]   rd_ptr;

  // LAG_MAX is a power of two, so pointer arithmetic wraps for free.
  assign rd_ptr = wr_ptr - lag;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_bit <= 1'b0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_bit;
      wr_ptr      <= wr_ptr + LAG_W'(1);
      rd_bit      <= (lag == '0) ? wr_bit : mem[rd_ptr];
    end
  end
endmodule

// File: rtl/qcorr_gen.sv
// Frame-based 1-bit sign correlator: XNOR of sign(A[n]) and sign(B[n-lag]), one strobe per accepted pair.
// Strobe lands 2 cycles after the accepting edge; in_ready only in WAIT_IN, so pacing is set by the gaps.
import pkg_parameters::*;

module qcorr_gen #(
  parameter int SAMPLING_RATE = 48,
  parameter int TIME_WINDOW   = 10,
  parameter int LAG_MAX       = 64,
  parameter int MIN_GAP       = 4,
  parameter int FRAME_GAP     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  qcorr_gen_if.slave  bus
);
  localparam int TOTAL_SAMPLES = SAMPLING_RATE * TIME_WINDOW;
  localparam int LAG_W         = $clog2(LAG_MAX);
  localparam int SW            = FEATURE_MAP_RESOLUTION;

  qcorr_gen_state_t state;
  logic [15:0]      cnt;
  logic [15:0]      gcnt;
  logic [LAG_W-1:0] lag_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             rd_bit;
  logic             wr_en;
  logic             rdy_q;
  logic             vld_q;
  logic             dat_q;
  logic             done_q;

  assign wr_en = (state == COMPUTE);

  qcorr_sign_delay #(
    .LAG_MAX(LAG_MAX),
    .LAG_W  (LAG_W)
  ) u_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .wr_en (wr_en),
    .wr_bit(sign_b_q),
    .lag   (lag_q),
    .rd_bit(rd_bit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      lag_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      dat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      dat_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable_i) begin
            lag_q <= bus.lag_i;
            cnt   <= '0;
            rdy_q <= 1'b1;
            state <= WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (bus.in_valid_i) begin
            sign_a_q <= bus.in_a_i[SW-1];
            sign_b_q <= bus.in_b_i[SW-1];
            rdy_q    <= 1'b0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: state <= EMIT;
        EMIT: begin
          vld_q <= 1'b1;
          dat_q <= ~(sign_a_q ^ rd_bit);
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: begin
          if (gcnt == 16'(MIN_GAP - 1)) begin
            gcnt <= '0;
            // Counter stops at the last index, so it can never wrap.
            if (cnt < 16'(TOTAL_SAMPLES - 1)) begin
              cnt   <= cnt + 16'd1;
              rdy_q <= 1'b1;
              state <= WAIT_IN;
            end else begin
              done_q <= 1'b1;
              state  <= FGAP;
            end
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        FGAP: begin
          if (gcnt == 16'(FRAME_GAP - 1)) begin
            gcnt <= '0;
            if (bus.enable_i) begin
              lag_q <= bus.lag_i;
              cnt   <= '0;
              rdy_q <= 1'b1;
              state <= WAIT_IN;
            end else begin
              state <= IDLE;
            end
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o    = rdy_q;
  assign bus.qcorr_valid_o = vld_q;
  assign bus.qcorr_data_o  = dat_q;
  assign bus.frame_done_o  = done_q;
endmodule

// File: tb/tb_qcorr_gen.sv
// Directed plus random bench for qcorr_gen, checked against a sign-history reference model.
module tb_qcorr_gen;
  import pkg_parameters::*;

  localparam int SR    = 2;
  localparam int TW    = 2;
  localparam int LM    = 8;
  localparam int MG    = 4;
  localparam int FG    = 4;
  localparam int LW    = $clog2(LM);
  localparam int W     = FEATURE_MAP_RESOLUTION;
  localparam int TOTAL = SR * TW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   cyc = 0;
  int   last_pulse = -1;
  int   fs;
  int   hi;
  bit   bhist[$];
  int   lag_m = 0;

  qcorr_gen_if #(.LAG_W(LW)) ifc();

  qcorr_gen #(
    .SAMPLING_RATE(SR),
    .TIME_WINDOW  (TW),
    .LAG_MAX      (LM),
    .MIN_GAP      (MG),
    .FRAME_GAP    (FG)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (ifc.qcorr_valid_o === 1'b1) strobes++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected bit: same sign as the B sample 'lag' acceptances ago; zeros before any history.
  function automatic bit model(bit sa, bit sb);
    int n;
    bit r;
    bhist.push_back(sb);
    n = bhist.size() - 1;
    r = (n - lag_m >= 0) ? bhist[n - lag_m] : 1'b0;
    return (sa == r);
  endfunction

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    bit e;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (ifc.in_ready_o === 1'b1);
    end
    chk("rdy_wait", got, 1);
    if (!got) return;
    ifc.in_a_i = a;
    ifc.in_b_i = b;
    ifc.in_valid_i = 1'b1;
    e = model(a[W-1], b[W-1]);
    @(negedge clk);
    ifc.in_valid_i = 1'b0;
    ifc.in_a_i = W'($urandom);
    ifc.in_b_i = W'($urandom);
    chk("rdy_drop", ifc.in_ready_o, 0);
    chk("vld_early", ifc.qcorr_valid_o, 0);
    @(negedge clk);
    chk("vld_pre", ifc.qcorr_valid_o, 0);
    @(negedge clk);
    chk("vld", ifc.qcorr_valid_o, 1);
    chk("data", ifc.qcorr_data_o, e);
    chk("fdone_early", ifc.frame_done_o, 0);
    if (last_pulse >= 0) chk("min_gap", (cyc - last_pulse) > MG, 1);
    last_pulse = cyc;
  endtask

  task automatic wait_done(input bit en_next, input int new_lag, input int start);
    bit got = 0;
    int low;
    int ups;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (ifc.frame_done_o === 1'b1);
    end
    chk("fdone_seen", got, 1);
    if (!got) return;
    chk("frame_strobes", strobes - start, TOTAL);
    chk("rdy_at_done", ifc.in_ready_o, 0);
    ifc.enable_i = en_next;
    ifc.lag_i = LW'(new_lag);
    if (en_next) lag_m = new_lag;
    @(negedge clk);
    chk("fdone_width", ifc.frame_done_o, 0);
    if (en_next) begin
      low = 1;
      for (int i = 0; i < 30 && ifc.in_ready_o !== 1'b1; i++) begin
        low++;
        @(negedge clk);
      end
      chk("fgap_low", low >= FG, 1);
      chk("restart_rdy", ifc.in_ready_o, 1);
    end else begin
      ups = 0;
      repeat (20) begin
        @(negedge clk);
        if (ifc.in_ready_o !== 1'b0) ups++;
      end
      chk("idle_rdy", ups, 0);
      chk("idle_strobes", strobes - start, TOTAL);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rdy"}, ifc.in_ready_o, 0);
    chk({tag, "_vld"}, ifc.qcorr_valid_o, 0);
    chk({tag, "_dat"}, ifc.qcorr_data_o, 0);
    chk({tag, "_done"}, ifc.frame_done_o, 0);
  endtask

  initial begin
    ifc.enable_i = 1'b0;
    ifc.lag_i = '0;
    ifc.in_valid_i = 1'b0;
    ifc.in_a_i = '0;
    ifc.in_b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");

    // Frame 1: lag 0, directed then random; lag_i wiggled mid-frame.
    rst_n = 1'b1;
    ifc.enable_i = 1'b1;
    ifc.lag_i = '0;
    lag_m = 0;
    fs = strobes;
    @(negedge clk);
    chk("rdy_1cyc", ifc.in_ready_o, 1);
    send_pair(8'd5, 8'd3);
    ifc.lag_i = 3'd5;
    send_pair(8'd5, 8'hFD);
    send_pair(W'($urandom), W'($urandom));
    send_pair(W'($urandom), W'($urandom));
    wait_done(1'b0, 0, fs);

    // Fresh history, lag 2; enable dropped after the first sample.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("reset2");
    bhist.delete();
    last_pulse = -1;
    ifc.lag_i = 3'd2;
    lag_m = 2;
    ifc.enable_i = 1'b1;
    fs = strobes;
    send_pair(8'd10, 8'd7);
    ifc.enable_i = 1'b0;
    send_pair(8'd20, 8'hF0);
    send_pair(8'd1, 8'd0);
    send_pair(8'd127, 8'd100);
    wait_done(1'b0, 0, fs);

    // Back-to-back random frames; the pointer wraps several times.
    lag_m = $urandom_range(0, LM - 1);
    ifc.lag_i = LW'(lag_m);
    ifc.enable_i = 1'b1;
    for (int f = 0; f < 4; f++) begin
      fs = strobes;
      for (int k = 0; k < TOTAL; k++) begin
        send_pair(W'($urandom), W'($urandom));
        if (k == 0) ifc.lag_i = LW'($urandom_range(0, LM - 1));
      end
      wait_done(f < 3, $urandom_range(0, LM - 1), fs);
    end

    // Reset between the 2nd and 3rd strobe abandons the frame.
    lag_m = 1;
    ifc.lag_i = 3'd1;
    ifc.enable_i = 1'b1;
    send_pair(W'($urandom), W'($urandom));
    send_pair(W'($urandom), W'($urandom));
    rst_n = 1'b0;
    ifc.enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("midrst");
    fs = strobes;
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.in_ready_o !== 1'b0 || ifc.qcorr_valid_o !== 1'b0 || ifc.frame_done_o !== 1'b0) hi++;
    end
    chk("post_rst_quiet", hi, 0);
    chk("post_rst_strobes", strobes - fs, 0);
    bhist.delete();
    last_pulse = -1;
    lag_m = 3;
    ifc.lag_i = 3'd3;
    ifc.enable_i = 1'b1;
    fs = strobes;
    for (int k = 0; k < TOTAL; k++) send_pair(W'($urandom), W'($urandom));
    wait_done(1'b0, 0, fs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qcorr_gen.md
QCORR_GEN -- requirements
Module: qcorr_gen

Interface
REQ-001 Parameter SAMPLING_RATE, default 48, samples per second of the input stream.
REQ-002 Parameter TIME_WINDOW, default 10, frame length in seconds; TOTAL_SAMPLES = SAMPLING_RATE*TIME_WINDOW bits per frame.
REQ-003 Parameter LAG_MAX, default 64, power of two, depth of the B-sign delay line.
REQ-004 Parameter MIN_GAP, default 4, minimum idle cycles between qcorr_valid_o pulses.
REQ-005 Parameter FRAME_GAP, default 4, extra idle cycles after the last bit of a frame.
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_ni  in  1  reset, synchronous, active-low.
REQ-008 enable_i  in  1  level; high permits starting a new frame.
REQ-009 lag_i  in  $clog2(LAG_MAX)  B-stream lag in samples; latched at frame start.
REQ-010 in_valid_i  in  1  sample pair valid.
REQ-011 in_a_i  in  FEATURE_MAP_RESOLUTION signed  sample of stream A.
REQ-012 in_b_i  in  FEATURE_MAP_RESOLUTION signed  sample of stream B.
REQ-013 in_ready_o  out  1  sample pair accepted when in_valid_i & in_ready_o.
REQ-014 qcorr_valid_o  out  1  single-cycle strobe, one per correlation bit.
REQ-015 qcorr_data_o  out  1  correlation bit; valid only while qcorr_valid_o.
REQ-016 frame_done_o  out  1  single-cycle pulse after the last bit of a frame.

Function
REQ-017 Sign of a sample SHALL be its MSB; 0 = non-negative.
REQ-018 qcorr_data_o SHALL equal XNOR(sign(A[n]), sign(B[n-lag])); 1 = same sign, 0 = opposite.
REQ-019 lag=0 SHALL use the B sample of the same handshake; delay line write and read of the same slot SHALL return the newly written sign.
REQ-020 FSM states: IDLE, WAIT_IN, COMPUTE, EMIT, GAP, FGAP.
REQ-021 IDLE -> WAIT_IN when enable_i=1; lag_i latched, sample counter cleared on that transition.
REQ-022 WAIT_IN: in_ready_o=1 only in this state; handshake -> COMPUTE, signs registered.
REQ-023 COMPUTE: B sign written to delay line, delayed sign read, bit formed; -> EMIT.
REQ-024 EMIT: qcorr_valid_o=1 for exactly one cycle, exactly 2 cycles after the accepting edge; -> GAP.
REQ-025 GAP: MIN_GAP cycles low; then WAIT_IN if counter < TOTAL_SAMPLES-1 (counter += 1), else FGAP.
REQ-026 FGAP: frame_done_o=1 on its first cycle only; after FRAME_GAP cycles -> WAIT_IN (counter cleared, lag_i relatched) if enable_i=1, else IDLE.
REQ-027 enable_i deasserted mid-frame SHALL NOT abort the frame; it takes effect only at the FGAP exit.
REQ-028 Sample counter: 16 bits unsigned, saturates at TOTAL_SAMPLES-1, never wraps.
REQ-029 Delay line: circular, LAG_MAX entries of 1 bit, pointer wraps LAG_MAX-1 -> 0; history persists across frames.
REQ-030 lag_i changes while not latching SHALL have no effect on the current frame.
REQ-031 in_valid_i held high outside WAIT_IN SHALL not be consumed; data is sampled only on handshake.

Reset
REQ-032 rst_ni=0 at a clock edge SHALL force IDLE, counter 0, write pointer 0, all delay-line bits 0, latched lag 0.
REQ-033 During and after reset: in_ready_o=0, qcorr_valid_o=0, qcorr_data_o=0, frame_done_o=0.
REQ-034 Reset mid-frame SHALL discard the partial frame with no further strobes.

Structure
REQ-035 State typedef (qcorr_gen_state_t) and QCORR_LAG_W constant SHALL live in pkg_parameters; FEATURE_MAP_RESOLUTION taken from there.
REQ-036 Delay line SHALL be sub-module qcorr_sign_delay (write bit, read at pointer-lag, synchronous clear).
REQ-037 All outputs SHALL be registered; no combinational path input -> output.

Verification
REQ-038 Reset, enable=1, lag=0, A=+5,B=+3 -> in_ready after 1 cycle, qcorr_valid 2 cycles post-handshake, data=1.
REQ-039 lag=0, A=+5,B=-3 -> data=0; next pulse no earlier than MIN_GAP+1 cycles later.
REQ-040 lag=2, B signs +,-,+,+ with A all positive -> bits 1,1,1,0 (zeros from reset history first two).
REQ-041 SAMPLING_RATE=2,TIME_WINDOW=2: feed 4 pairs -> exactly 4 strobes, frame_done after 4th, in_ready low FRAME_GAP+ cycles.
REQ-042 enable_i dropped after 1st of 4 samples -> frame completes 4 strobes, then IDLE, in_ready stays 0.
REQ-043 rst_ni low for one cycle between 2nd and 3rd strobe -> no further strobes, all outputs 0, new frame restarts count at 0.
